// File: rtl/frame_buf_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong frame buffer controller.
// A bank index is a single bit because the memory is split into two halves.
package fb_pkg;
    localparam int FB_BANKS = 2;
    typedef logic bank_t;
endpackage

// File: rtl/frame_buf_pingpong_ctrl_if.sv
// Producer stream, consumer stream and dual-port memory signals of the controller.
// The controller takes the slave view; the surrounding system (source, sink, memory) takes the master view.
interface frame_buf_pingpong_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  frame_wr_done;
    logic                  frame_rd_done;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH:0]   mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH:0]   mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rd_data,
        output in_ready, out_valid, out_data, out_last, frame_wr_done, frame_rd_done,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_data, out_last, frame_wr_done, frame_rd_done,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/frame_buf_pingpong_ctrl_skid_buf.sv
// Two-entry FIFO that catches registered memory read data so the consumer can stall freely.
// The caller's read credit guarantees a push never arrives while both entries are occupied.
module fb_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] entry_q [2];
    logic             wr_idx_q;
    logic             rd_idx_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i & (count_q != 2'd0);
        count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                entry_q[wr_idx_q] <= push_data_i;
                wr_idx_q          <= ~wr_idx_q;
            end
            if (do_pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = entry_q[rd_idx_q];
    assign count_o = count_q;
endmodule

// File: rtl/frame_buf_pingpong_ctrl.sv
// Ping-pong controller: the producer fills one memory bank while the consumer drains the other,
// and the banks swap roles each time a full frame has been written or read out.
module frame_buf_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    frame_buf_pingpong_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    bank_t                 wr_bank_q, wr_bank_d;
    bank_t                 rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FB_BANKS-1:0]   bank_full_q, bank_full_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  rd_last_q, rd_last_d;

    logic                  in_ready;
    logic                  wr_accept;
    logic                  wr_frame_end;
    logic                  rd_issue;
    logic                  rd_frame_end;
    logic                  out_pop;
    logic [1:0]            skid_count;
    logic [1:0]            skid_occ;
    logic                  skid_valid;
    logic [DATA_WIDTH:0]   skid_data;

    // The word leaving the skid this cycle frees its slot, so it is credited back
    // immediately; without that the reader would bubble instead of streaming one word per cycle.
    always_comb begin
        in_ready     = !bank_full_q[wr_bank_q];
        wr_accept    = bus.in_valid & in_ready;
        wr_frame_end = wr_accept & (wr_ptr_q == PTR_LAST);
        out_pop      = skid_valid & bus.out_ready;
        skid_occ     = skid_count + {1'b0, rd_inflight_q} - {1'b0, out_pop};
        rd_issue     = bank_full_q[rd_bank_q] & (skid_occ < 2'd2);
        rd_frame_end = rd_issue & (rd_ptr_q == PTR_LAST);

        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        rd_ptr_d      = rd_ptr_q;
        rd_bank_d     = rd_bank_q;
        bank_full_d   = bank_full_q;
        rd_inflight_d = rd_issue;
        rd_last_d     = rd_frame_end;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (wr_frame_end) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        // The write bank is always empty and the read bank full, so these never collide.
        if (rd_frame_end) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            bank_full_q   <= '0;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            bank_full_q   <= bank_full_d;
            rd_inflight_q <= rd_inflight_d;
            rd_last_q     <= rd_last_d;
        end
    end

    fb_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rd_inflight_q),
        .push_data_i({rd_last_q, bus.mem_rd_data}),
        .pop_i      (out_pop),
        .valid_o    (skid_valid),
        .data_o     (skid_data),
        .count_o    (skid_count)
    );

    assign bus.in_ready      = in_ready;
    assign bus.mem_wr_en     = wr_accept;
    assign bus.mem_wr_addr   = {wr_bank_q, wr_ptr_q};
    assign bus.mem_wr_data   = bus.in_data;
    assign bus.frame_wr_done = wr_frame_end;
    assign bus.mem_rd_en     = rd_issue;
    assign bus.mem_rd_addr   = {rd_bank_q, rd_ptr_q};
    assign bus.out_valid     = skid_valid;
    assign bus.out_data      = skid_data[DATA_WIDTH-1:0];
    assign bus.out_last      = skid_valid & skid_data[DATA_WIDTH];
    assign bus.frame_rd_done = out_pop & skid_data[DATA_WIDTH];
endmodule

// File: tb/tb_frame_buf_pingpong_ctrl.sv
// Self-checking bench for the ping-pong frame buffer controller with a behavioural memory,
// a word-count/queue reference model checked every cycle, and directed literal expectations.
module tb_frame_buf_pingpong_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    frame_buf_pingpong_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    frame_buf_pingpong_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [15:0] memArray [16];

    always @(posedge clk) begin
        if (bus.mem_wr_en) memArray[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= memArray[bus.mem_rd_addr];
    end

    int          checkCount = 0;
    int          passCount = 0;
    logic [15:0] expQ [$];
    int          wrCount = 0;
    int          popCount = 0;
    int          issuedTotal = 0;
    int          prevTotal = 0;
    bit          lastAccept = 1'b0;
    bit          toggleReady = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic inValid, input logic [15:0] inData);
        bus.in_valid = inValid;
        bus.in_data  = inData;
    endtask

    // Reference: a bank holds a frame from its last write until its last read is issued;
    // reads return two cycles after issue; outstanding words (issued, not consumed) never exceed two.
    task automatic modelCheck();
        int occupied;
        bit accept, pop, expOutValid, expRdEn, expInReady;
        if (reset) begin
            expQ.delete();
            wrCount = 0; popCount = 0; issuedTotal = 0; prevTotal = 0; lastAccept = 1'b0;
            return;
        end
        occupied    = wrCount / 8 - issuedTotal / 8;
        expInReady  = (occupied < 2);
        accept      = bus.in_valid && expInReady;
        expOutValid = (prevTotal - popCount) > 0;
        pop         = expOutValid && bus.out_ready;
        expRdEn     = (occupied > 0) && ((issuedTotal - popCount - int'(pop)) < 2);

        checkOutput("in_ready", 32'(bus.in_ready), 32'(expInReady));
        checkOutput("mem_wr_en", 32'(bus.mem_wr_en), 32'(accept));
        checkOutput("mem_wr_addr", 32'(bus.mem_wr_addr), 32'(wrCount % 16));
        checkOutput("mem_wr_data", 32'(bus.mem_wr_data), 32'(bus.in_data));
        checkOutput("frame_wr_done", 32'(bus.frame_wr_done), 32'(accept && (wrCount % 8 == 7)));
        checkOutput("mem_rd_en", 32'(bus.mem_rd_en), 32'(expRdEn));
        checkOutput("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(issuedTotal % 16));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(expOutValid));
        checkOutput("frame_rd_done", 32'(bus.frame_rd_done), 32'(pop && (popCount % 8 == 7)));
        if (expOutValid) begin
            checkOutput("out_data", 32'(bus.out_data), 32'(expQ[0]));
            checkOutput("out_last", 32'(bus.out_last), 32'(popCount % 8 == 7));
        end

        if (accept) begin
            expQ.push_back(bus.in_data);
            wrCount++;
        end
        if (pop) begin
            void'(expQ.pop_front());
            popCount++;
        end
        prevTotal   = issuedTotal;
        issuedTotal = issuedTotal + int'(expRdEn);
        lastAccept  = accept;
    endtask

    task automatic tick();
        @(negedge clk);
        modelCheck();
        @(posedge clk);
        #1;
        if (toggleReady) bus.out_ready = ~bus.out_ready;
    endtask

    task automatic sendWord(input logic [15:0] v);
        int waited = 0;
        applyStimulus(1'b1, v);
        do begin
            tick();
            waited++;
        end while (!lastAccept && waited < 100);
        if (!lastAccept) begin
            checkCount++;
            $display("[TB] FAIL sendWord: word 0x%0h not accepted, required acceptance within 100 cycles", v);
        end
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (expQ.size() != 0 && waited < 200) begin
            tick();
            waited++;
        end
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d words still pending, required 0", expQ.size());
        end
    endtask

    task automatic waitPops(input int n);
        int base = popCount;
        int waited = 0;
        while (popCount - base < n && waited < 100) begin
            tick();
            waited++;
        end
        if (popCount - base < n) begin
            checkCount++;
            $display("[TB] FAIL waitPops: %0d words consumed, required %0d", popCount - base, n);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0);
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        checkOutput("rst mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        checkOutput("rst mem_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        checkOutput("rst mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);

        // Single frame, latency and consecutive output
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) sendWord(16'(i));
        applyStimulus(1'b1, 16'h8);
        checkOutput("t2 frame_wr_done", 32'(bus.frame_wr_done), 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0);
        checkOutput("t2 lat1 out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("t2 lat2 out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick();
            checkOutput("t2 out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("t2 out_data", 32'(bus.out_data), 32'(i));
            checkOutput("t2 out_last", 32'(bus.out_last), 32'(i == 8));
            checkOutput("t2 frame_rd_done", 32'(bus.frame_rd_done), 32'(i == 8));
        end
        tick();

        // Both banks full under consumer stall
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) sendWord(16'(i));
        applyStimulus(1'b1, 16'h11);
        checkOutput("t3 in_ready full", 32'(bus.in_ready), 32'd0);
        checkOutput("t3 mem_wr_en full", 32'(bus.mem_wr_en), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t3 mem_wr_en held", 32'(bus.mem_wr_en), 32'd0);
        applyStimulus(1'b0, 16'h0);
        bus.out_ready = 1'b1;
        waitDrain();

        // Toggling consumer, three continuous frames
        toggleReady = 1'b1;
        for (int i = 0; i < 24; i++) sendWord(16'h100 + 16'(i));
        applyStimulus(1'b0, 16'h0);
        waitDrain();
        toggleReady = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Four frames back to back, bank alternation
        checkOutput("t5 start wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        checkOutput("t5 start rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        for (int i = 0; i < 32; i++) begin
            sendWord(16'h200 + 16'(i));
            if (i % 8 == 7) checkOutput("t5 wr_addr bank", 32'(bus.mem_wr_addr), 32'((i + 1) % 16));
        end
        applyStimulus(1'b0, 16'h0);
        waitDrain();

        // Reset in the middle of reading out a frame
        for (int i = 0; i < 8; i++) sendWord(16'h300 + 16'(i));
        applyStimulus(1'b0, 16'h0);
        waitPops(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6 out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6 in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("t6 mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        checkOutput("t6 mem_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        for (int i = 0; i < 8; i++) sendWord(16'h400 + 16'(i));
        applyStimulus(1'b0, 16'h0);
        waitDrain();
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
